module_debounce_sync: RTL
=========================

// Module: module_debounce_sync
// PURPOSE
//  Multi-channel input conditioner for GPIO/button inputs entering the core clock domain.
//  - Synchronises each bit through an N-stage flop chain.
//  - Debounces each bit by requiring a stable level for a programmable number of cycles.
//  - Emits one-cycle rise/fall pulses on the filtered level.
//  - Latches enabled edges into sticky pending flags that drive one interrupt line to the core.
// PARAMETERS
//  LEN       2  number of independent input channels
//  STAGES    2  synchroniser flop stages (>=2)
//  DEBOUNCE  4  consecutive differing samples needed to accept a new level (>=1; 1 = no filtering)
// PORTS
//  clk          in   1    core clock, all flops on rising edge
//  reset        in   1    asynchronous, active-high reset
//  en           in   1    1 = sample/filter; 0 = freeze chain, counters and levels
//  data_in      in   LEN  asynchronous raw inputs
//  data_out     out  LEN  debounced, synchronised level (registered)
//  rise         out  LEN  1-cycle pulse when data_out[i] goes 0->1
//  fall         out  LEN  1-cycle pulse when data_out[i] goes 1->0
//  irq_rise_en  in   LEN  per-channel enable: rise sets pending
//  irq_fall_en  in   LEN  per-channel enable: fall sets pending
//  pending_clr  in   LEN  write-1-to-clear strobe for pending
//  pending      out  LEN  sticky edge-event flags (registered)
//  irq          out  1    |pending (combinational OR of registers)
// BEHAVIOUR
//  - Reset: all sync stages, counters, data_out, rise, fall and pending are set to 0; irq is 0.
//  - Sync: sync[i] is data_in[i] delayed by STAGES edges while en=1.
//  - Debounce, per channel, at each edge with en=1:
//    - sync == data_out: cnt <= 0.
//    - sync != data_out and cnt == DEBOUNCE-1: data_out <= sync; cnt <= 0; rise/fall <= the matching edge.
//    - otherwise: cnt <= cnt+1.
//  - Latency: a data_in change held stable appears on data_out after exactly STAGES+DEBOUNCE rising edges.
//  - Glitch rejection: a change lasting fewer than DEBOUNCE samples at the sync output never reaches data_out.
//  - Counter width is CNT_W = $clog2(DEBOUNCE+1); cnt never exceeds DEBOUNCE-1 (no wrap).
//  - rise/fall:
//    - Registered, asserted in the same cycle data_out changes, high for exactly one cycle.
//    - rise and fall are never both high for one channel.
//  - en=0:
//    - Chain, cnt and data_out hold.
//    - rise and fall are 0.
//    - pending holds but pending_clr still acts.
//    - Counting resumes from the held cnt when en returns to 1.
//  - pending[i], one cycle after the pulse:
//    - Set when (rise[i] & irq_rise_en[i]) | (fall[i] & irq_fall_en[i]).
//    - Cleared by pending_clr[i].
//    - Set and clear in the same cycle: set wins.
//  - A level that is already high when reset is released is reported as a normal rise after STAGES+DEBOUNCE edges.
//  - Reset asserted mid-count: the in-progress count is discarded and no pulse is emitted.
// STRUCTURE
//  - Package debounce_pkg: function cnt_width(DEBOUNCE) returning $clog2(DEBOUNCE+1). No typedefs needed.
//  - Sub-module module_debounce_channel (1 bit):
//    - Contains the counter, the stable level register and the rise/fall registers.
//    - Instantiated LEN times in a generate loop.
//  - Top level holds:
//    - the STAGES x LEN sync chain, with asynchronous reset, kept local;
//    - the pending logic;
//    - the irq OR.
// TESTING (LEN=2, STAGES=2, DEBOUNCE=4, clk period 2)
//  1. Reset held with data_in=11, release
//     -> outputs 0 during reset; data_out=11 at edge 6 after release; rise=11 for 1 cycle; pending=00.
//  2. Glitch: data_in[0] 0->1 for 3 cycles then back to 0
//     -> data_out, rise and pending stay 0 throughout.
//  3. irq_rise_en=01; data_in 00->01
//     -> rise=01 for 1 cycle at edge 6; pending=01 and irq=1 next cycle.
//     Then pending_clr=01 for 1 cycle -> pending=00, irq=0.
//  4. irq_fall_en=10; data_in[1] 1->0 timed so the fall-driven set coincides with pending_clr=10
//     -> pending[1]=1 (set wins); fall=10 pulse observed.
//  5. en=0 after 2 counted samples of a new level, held 10 cycles, then en=1
//     -> data_out frozen while en=0; changes 2 edges after re-enable.
//  6. Async reset asserted mid-count (between edges)
//     -> all outputs 0 immediately, with no rise/fall pulse after release until a new full STAGES+DEBOUNCE window.

Source files
------------

// File: rtl/debounce_pkg.sv
`timescale 1ns / 1ps
// Shared helpers for the input conditioner.
//   cnt_width(debounce): width of a counter that must hold values 0..debounce.
package debounce_pkg;

  function automatic int unsigned cnt_width(input int unsigned debounce);
    return $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/module_debounce_channel.sv
`timescale 1ns / 1ps
// Single-bit debounce filter with edge pulse outputs.
// Ports:
//   clk      in   core clock
//   reset    in   asynchronous, active-high reset
//   en       in   1 = filter advances; 0 = counter and level hold, pulses forced low
//   sync_in  in   already-synchronised input bit
//   level    out  accepted (debounced) level, registered
//   rise     out  one-cycle pulse when level goes 0->1
//   fall     out  one-cycle pulse when level goes 1->0
module module_debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en) begin
      if (sync_in == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        // DEBOUNCE consecutive differing samples seen: accept the new level.
        level_d = sync_in;
        cnt_d   = '0;
        rise_d  = sync_in;
        fall_d  = ~sync_in;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/module_debounce_sync.sv
`timescale 1ns / 1ps
// Multi-channel GPIO/button input conditioner: synchroniser chain, per-channel debounce,
// edge pulses, sticky pending flags and a single interrupt line.
// Ports:
//   clk          in   core clock
//   reset        in   asynchronous, active-high reset
//   en           in   1 = sample/filter; 0 = freeze chain, counters and levels
//   data_in      in   LEN raw asynchronous inputs
//   data_out     out  LEN debounced, synchronised levels
//   rise         out  LEN one-cycle 0->1 pulses on data_out
//   fall         out  LEN one-cycle 1->0 pulses on data_out
//   irq_rise_en  in   LEN per-channel: rise sets pending
//   irq_fall_en  in   LEN per-channel: fall sets pending
//   pending_clr  in   LEN write-1-to-clear strobe for pending
//   pending      out  LEN sticky edge-event flags
//   irq          out  OR of all pending flags
module module_debounce_sync
  import debounce_pkg::*;
#(
  parameter int unsigned LEN      = 2,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [LEN-1:0] data_in,
  output logic [LEN-1:0] data_out,
  output logic [LEN-1:0] rise,
  output logic [LEN-1:0] fall,
  input  logic [LEN-1:0] irq_rise_en,
  input  logic [LEN-1:0] irq_fall_en,
  input  logic [LEN-1:0] pending_clr,
  output logic [LEN-1:0] pending,
  output logic           irq
);

  // Synchroniser chain; stage 0 is the metastability-exposed flop.
  logic [LEN-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else if (en) begin
      sync_q[0] <= data_in;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  for (genvar i = 0; i < LEN; i++) begin : g_chan
    module_debounce_channel #(
      .DEBOUNCE (DEBOUNCE)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .sync_in (sync_q[STAGES-1][i]),
      .level   (data_out[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  logic [LEN-1:0] pending_q, pending_d, pending_set;

  always_comb begin
    pending_set = (rise & irq_rise_en) | (fall & irq_fall_en);
    // A new event in the same cycle as a clear must not be lost: set wins.
    pending_d   = (pending_q & ~pending_clr) | pending_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign irq     = |pending_q;

endmodule
